// File: rtl/mult_seq_unit.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are converted to magnitudes when the multiply is accepted. One multiplier bit
// is consumed per cycle. The sign is applied once, at the end, over the full 2*WIDTH
// product. Latency is fixed: done rises WIDTH+1 edges after the accepting edge.
module mult_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_a,
    input  logic             signed_b,
    input  logic             half,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;   // |a| pre-shifted by the current count
    logic [WIDTH-1:0]     mplier_q, mplier_d; // |b|, shifted right so bit 0 is the active bit
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic                 half_q, half_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 done_q, done_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 accept;
    logic [2*WIDTH-1:0]   prod;

    // Operand magnitudes; the most-negative value maps onto 2^(WIDTH-1), which still fits.
    always_comb begin
        a_neg  = signed_a & a[WIDTH-1];
        b_neg  = signed_b & b[WIDTH-1];
        a_mag  = a_neg ? (~a + 1'b1) : a;
        b_mag  = b_neg ? (~b + 1'b1) : b;
        accept = (state_q == StIdle) && start && !flush;
        prod   = neg_q ? (~acc_q + 1'b1) : acc_q;
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush always returns to idle and wins over a new start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (count_q == LastCount) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath next-state: latch on accept, accumulate in CALC, sign-fix and publish in FIX.
    always_comb begin
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        half_d   = half_q;
        result_d = result_q;
        done_d   = 1'b0;

        if (accept) begin
            count_d  = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            neg_d    = a_neg ^ b_neg;
            half_d   = half;
        end else if (state_q == StCalc && !flush) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
        end else if (state_q == StFix && !flush) begin
            result_d = half_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
            done_d   = 1'b1;
        end
    end

    // Datapath registers; reset discards any operation in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            half_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            half_q   <= half_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Outputs.
    always_comb begin
        busy   = (state_q != StIdle);
        done   = done_q;
        result = result_q;
    end

endmodule
